// File: rtl/jpeg_pkg.sv
// Shared JPEG constants: block geometry and the zig-zag scan order
// (zig-zag position -> raster index) reused by the entropy-stage blocks.
package jpeg_pkg;

  localparam int BLOCK_DEPTH  = 64;
  localparam int SAMPLE_WIDTH = 8;

  localparam logic [5:0] ZIGZAG [BLOCK_DEPTH] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

endpackage

// File: rtl/zigzag_rom.sv
// Combinational zig-zag lookup: scan position to raster sample index.
module zigzag_rom
  import jpeg_pkg::*;
(
  input  logic [5:0] pos_i,
  output logic [5:0] raster_idx_o
);

  assign raster_idx_o = ZIGZAG[pos_i];

endmodule

// File: rtl/zigzag_scan_64x8bit.sv
// Ping-pong 8x8 block buffer that re-emits each raster block in JPEG
// zig-zag order, one sample per accepted transfer.
module zigzag_scan_64x8bit
  import jpeg_pkg::*;
#(
  parameter int DATA_WIDTH = SAMPLE_WIDTH,
  parameter int DEPTH      = BLOCK_DEPTH
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        block_valid,
  output logic                        block_ready,
  input  logic [DATA_WIDTH*DEPTH-1:0] block_data,
  output logic                        coef_valid,
  input  logic                        coef_ready,
  output logic [DATA_WIDTH-1:0]       coef_data,
  output logic [5:0]                  coef_index,
  output logic                        coef_last,
  output logic [15:0]                 block_count
);

  logic [DATA_WIDTH-1:0] bank_q [2][DEPTH];
  logic [1:0]            full_q, full_d;
  logic                  wr_sel_q, wr_sel_d;
  logic                  rd_sel_q, rd_sel_d;
  logic [5:0]            pos_q, pos_d;
  logic [15:0]           block_count_q, block_count_d;
  logic [5:0]            raster_idx;
  logic                  load, xfer, xfer_last;

  zigzag_rom u_rom (
    .pos_i        (pos_q),
    .raster_idx_o (raster_idx)
  );

  // Ready looks only at registered flags, so a bank freed this edge is
  // not reusable until the next cycle.
  assign block_ready = !full_q[wr_sel_q];
  assign load        = block_valid && block_ready;
  assign coef_valid  = full_q[rd_sel_q];
  assign xfer        = coef_valid && coef_ready;
  assign xfer_last   = xfer && (pos_q == 6'd63);

  assign coef_data   = bank_q[rd_sel_q][raster_idx];
  assign coef_index  = pos_q;
  assign coef_last   = coef_valid && (pos_q == 6'd63);
  assign block_count = block_count_q;

  always_comb begin
    full_d        = full_q;
    wr_sel_d      = wr_sel_q;
    rd_sel_d      = rd_sel_q;
    pos_d         = pos_q;
    block_count_d = block_count_q;
    if (load) begin
      full_d[wr_sel_q] = 1'b1;
      wr_sel_d         = !wr_sel_q;
    end
    if (xfer) begin
      pos_d = pos_q + 6'd1;
    end
    // Load and retire always target different banks, so both apply.
    if (xfer_last) begin
      full_d[rd_sel_q] = 1'b0;
      rd_sel_d         = !rd_sel_q;
      block_count_d    = block_count_q + 16'd1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      full_q        <= 2'b00;
      wr_sel_q      <= 1'b0;
      rd_sel_q      <= 1'b0;
      pos_q         <= 6'd0;
      block_count_q <= 16'd0;
    end else begin
      full_q        <= full_d;
      wr_sel_q      <= wr_sel_d;
      rd_sel_q      <= rd_sel_d;
      pos_q         <= pos_d;
      block_count_q <= block_count_d;
    end
  end

  // Sample k sits MSB-first in the packed input bus.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int b = 0; b < 2; b++) begin
        for (int k = 0; k < DEPTH; k++) begin
          bank_q[b][k] <= '0;
        end
      end
    end else if (load) begin
      for (int k = 0; k < DEPTH; k++) begin
        bank_q[wr_sel_q][k] <= block_data[DATA_WIDTH*DEPTH-1-k*DATA_WIDTH -: DATA_WIDTH];
      end
    end
  end

endmodule

// File: tb/tb_zigzag_scan_64x8bit.sv
// Directed bench for zigzag_scan_64x8bit: ordering, backpressure, ping-pong,
// simultaneous load/retire, mid-stream reset and block counter wrap.
module tb_zigzag_scan_64x8bit;

  localparam int ZZ [64] = '{
     0,  1,  8, 16,  9,  2,  3, 10, 17, 24, 32, 25, 18, 11,  4,  5,
    12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13,  6,  7, 14, 21, 28,
    35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
    58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63
  };

  logic         clock;
  logic         reset;
  logic         block_valid;
  logic         block_ready;
  logic [511:0] block_data;
  logic         coef_valid;
  logic         coef_ready;
  logic [7:0]   coef_data;
  logic [5:0]   coef_index;
  logic         coef_last;
  logic [15:0]  block_count;

  int n_cmp = 0;
  int n_mis = 0;

  zigzag_scan_64x8bit dut (
    .clock       (clock),
    .reset       (reset),
    .block_valid (block_valid),
    .block_ready (block_ready),
    .block_data  (block_data),
    .coef_valid  (coef_valid),
    .coef_ready  (coef_ready),
    .coef_data   (coef_data),
    .coef_index  (coef_index),
    .coef_last   (coef_last),
    .block_count (block_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, observed running expected finished");
    $fatal(1, "watchdog");
  end

  // mode 0: k, 1: 255-k, 2: k^3C, 3: k^C3, 4: k^5A
  function automatic logic [7:0] samp(input int mode, input int k);
    logic [7:0] kk;
    kk = 8'(k);
    case (mode)
      0:       return kk;
      1:       return 8'd255 - kk;
      2:       return kk ^ 8'h3C;
      3:       return kk ^ 8'hC3;
      default: return kk ^ 8'h5A;
    endcase
  endfunction

  function automatic logic [511:0] mkblk(input int mode);
    logic [511:0] b;
    b = '0;
    for (int k = 0; k < 64; k++) b[511-k*8 -: 8] = samp(mode, k);
    return b;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_elem(input string tag, input int mode, input int i);
    chk({tag, " valid"}, 32'(coef_valid), 32'd1);
    chk({tag, " index"}, 32'(coef_index), 32'(i));
    chk({tag, " data"},  32'(coef_data),  32'(samp(mode, ZZ[i])));
    chk({tag, " last"},  32'(coef_last),  32'(i == 63));
  endtask

  // Streams a whole block with coef_ready high, starting at its index 0.
  task automatic drain(input string tag, input int mode);
    for (int i = 0; i < 64; i++) begin
      chk_elem(tag, mode, i);
      @(negedge clock);
    end
  endtask

  initial begin
    reset       = 1'b1;
    block_valid = 1'b0;
    block_data  = '0;
    coef_ready  = 1'b1;

    // Reset values
    @(negedge clock);
    chk("rst block_ready", 32'(block_ready), 32'd1);
    chk("rst coef_valid",  32'(coef_valid),  32'd0);
    chk("rst coef_data",   32'(coef_data),   32'd0);
    chk("rst coef_index",  32'(coef_index),  32'd0);
    chk("rst coef_last",   32'(coef_last),   32'd0);
    chk("rst block_count", 32'(block_count), 32'd0);
    reset = 1'b0;
    @(negedge clock);

    // Ordering
    block_data  = mkblk(0);
    block_valid = 1'b1;
    chk("ord block_ready", 32'(block_ready), 32'd1);
    @(negedge clock);
    block_valid = 1'b0;
    drain("ord", 0);
    chk("ord valid after", 32'(coef_valid),  32'd0);
    chk("ord count",       32'(block_count), 32'd1);

    // Backpressure at index 10
    block_data  = mkblk(0);
    block_valid = 1'b1;
    @(negedge clock);
    block_valid = 1'b0;
    for (int i = 0; i < 64; i++) begin
      chk_elem("bp", 0, i);
      if (i == 10) begin
        coef_ready = 1'b0;
        repeat (5) begin
          @(negedge clock);
          chk("bp hold data",  32'(coef_data),  32'd32);
          chk("bp hold index", 32'(coef_index), 32'd10);
          chk("bp hold valid", 32'(coef_valid), 32'd1);
        end
        coef_ready = 1'b1;
      end
      @(negedge clock);
    end
    chk("bp valid after", 32'(coef_valid),  32'd0);
    chk("bp count",       32'(block_count), 32'd2);

    // Ping-pong: A (k), B (255-k), then C (k^3C) waits for a free bank
    coef_ready  = 1'b0;
    block_data  = mkblk(0);
    block_valid = 1'b1;
    chk("pp ready A", 32'(block_ready), 32'd1);
    @(negedge clock);
    chk("pp ready B", 32'(block_ready), 32'd1);
    chk("pp A first valid", 32'(coef_valid), 32'd1);
    chk("pp A first index", 32'(coef_index), 32'd0);
    chk("pp A first data",  32'(coef_data),  32'd0);
    block_data = mkblk(1);
    @(negedge clock);
    block_data = mkblk(2);
    coef_ready = 1'b1;
    for (int j = 0; j < 128; j++) begin
      chk_elem((j < 64) ? "pp A" : "pp B", (j < 64) ? 0 : 1, j % 64);
      if (j < 64) chk("pp ready full", 32'(block_ready), 32'd0);
      if (j == 64) chk("pp ready freed", 32'(block_ready), 32'd1);
      if (j == 65) begin
        chk("pp ready C taken", 32'(block_ready), 32'd0);
        block_valid = 1'b0;
      end
      @(negedge clock);
    end
    drain("pp C", 2);
    chk("pp valid after", 32'(coef_valid),  32'd0);
    chk("pp count",       32'(block_count), 32'd5);

    // Simultaneous load of E with the last transfer of D
    block_data  = mkblk(3);
    block_valid = 1'b1;
    @(negedge clock);
    block_valid = 1'b0;
    for (int i = 0; i < 64; i++) begin
      chk_elem("sim D", 3, i);
      if (i == 63) begin
        block_data  = mkblk(4);
        block_valid = 1'b1;
        chk("sim ready E", 32'(block_ready), 32'd1);
      end
      @(negedge clock);
    end
    block_valid = 1'b0;
    chk("sim count D", 32'(block_count), 32'd6);
    drain("sim E", 4);
    chk("sim count E", 32'(block_count), 32'd7);
    chk("sim valid after", 32'(coef_valid), 32'd0);

    // Asynchronous reset at index 20
    block_data  = mkblk(2);
    block_valid = 1'b1;
    @(negedge clock);
    block_valid = 1'b0;
    for (int i = 0; i <= 20; i++) begin
      chk_elem("mr", 2, i);
      if (i < 20) @(negedge clock);
    end
    #2 reset = 1'b1;
    #1;
    chk("mr async valid", 32'(coef_valid),  32'd0);
    chk("mr async index", 32'(coef_index),  32'd0);
    chk("mr async data",  32'(coef_data),   32'd0);
    chk("mr async last",  32'(coef_last),   32'd0);
    chk("mr async count", 32'(block_count), 32'd0);
    chk("mr async ready", 32'(block_ready), 32'd1);
    block_data  = mkblk(3);
    block_valid = 1'b1;
    @(negedge clock);
    block_valid = 1'b0;
    reset       = 1'b0;
    #1;
    chk("mr post ready", 32'(block_ready), 32'd1);
    chk("mr post valid", 32'(coef_valid),  32'd0);
    chk("mr post count", 32'(block_count), 32'd0);
    @(negedge clock);
    chk("mr idle valid", 32'(coef_valid), 32'd0);
    block_data  = mkblk(1);
    block_valid = 1'b1;
    @(negedge clock);
    block_valid = 1'b0;
    drain("mr fresh", 1);
    chk("mr fresh count", 32'(block_count), 32'd1);

    // Counter wrap
    force dut.block_count_q = 16'hFFFF;
    @(negedge clock);
    release dut.block_count_q;
    @(negedge clock);
    chk("wrap preload", 32'(block_count), 32'hFFFF);
    block_data  = mkblk(0);
    block_valid = 1'b1;
    @(negedge clock);
    block_valid = 1'b0;
    drain("wrap", 0);
    chk("wrap count", 32'(block_count), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
